cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline. It consumes the exception code, PC and delay-slot flag produced by the EX/MEM register together with the six hardware interrupt lines from Timer0/Timer1/external sources. It decides each cycle whether the instruction in M is taken as a victim. On a take it updates SR/Cause/EPC and asserts a flush/redirect request so fetch jumps to the handler at 0x00004180. It also services `mfc0`/`mtc0`/`eret` issued from the M stage.

---
 rtl/cp0_exc_ctrl_if.sv | 33 +++
 rtl/cp0_exc_ctrl.sv | 103 ++++++++++
 tb/tb_cp0_exc_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// Purpose: M-stage <-> CP0 connection bundle for the exception controller.
// Signals:
//   PC_M, ExcCode_M, Delayslot_M : victim candidate from EX/MEM
//   HWInt                        : level interrupt lines (bit0 Timer0, bit1 Timer1)
//   CP0_A, CP0_WD, CP0_WE        : mfc0/mtc0 address, write data, write enable
//   ERET_M                       : eret in M
//   CP0_RD, EPC_Out              : mfc0 read data, eret target
//   Req, NPC_Exc                 : flush/redirect request and handler address
// master = pipeline side, slave = CP0 side.
interface cp0_exc_ctrl_if;
    logic [31:0] PC_M;
    logic [4:0]  ExcCode_M;
    logic        Delayslot_M;
    logic [5:0]  HWInt;
    logic [4:0]  CP0_A;
    logic [31:0] CP0_WD;
    logic        CP0_WE;
    logic        ERET_M;
    logic [31:0] CP0_RD;
    logic [31:0] EPC_Out;
    logic        Req;
    logic [31:0] NPC_Exc;

    modport master (
        output PC_M, ExcCode_M, Delayslot_M, HWInt, CP0_A, CP0_WD, CP0_WE, ERET_M,
        input  CP0_RD, EPC_Out, Req, NPC_Exc
    );

    modport slave (
        input  PC_M, ExcCode_M, Delayslot_M, HWInt, CP0_A, CP0_WD, CP0_WE, ERET_M,
        output CP0_RD, EPC_Out, Req, NPC_Exc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Purpose: CP0 exception/interrupt controller. Decides each cycle whether the
// M-stage instruction is taken as a victim, updates SR/Cause/EPC on a take,
// and services mfc0/mtc0/eret from M.
// Ports:
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : cp0_exc_ctrl_if.slave (M-stage inputs, CP0_RD/EPC_Out/Req/NPC_Exc)
module cp0_exc_ctrl (
    input  logic clk,
    input  logic reset,
    cp0_exc_ctrl_if.slave bus
);
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] PRID_VAL   = 32'h1919_0817;

    localparam int unsigned IM_W   = 6;
    localparam int unsigned EXC_W  = 5;

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [IM_W-1:0]  r_sr_im;
    logic             r_sr_exl;
    logic             r_sr_ie;
    logic             r_cause_bd;
    logic [IM_W-1:0]  r_cause_ip;
    logic [EXC_W-1:0] r_cause_exc;
    logic [31:0]      r_epc;

    logic             w_int_req;
    logic             w_exc_req;
    logic             w_req;
    logic [31:0]      w_victim_pc;
    logic [31:0]      w_sr;
    logic [31:0]      w_cause;
    logic [31:0]      w_rd;

    // Take decision; interrupts use live HWInt, EXL blocks everything.
    assign w_int_req = r_sr_ie & ~r_sr_exl & (|(bus.HWInt & r_sr_im));
    assign w_exc_req = ~r_sr_exl & (bus.ExcCode_M != 5'd0);
    assign w_req     = w_int_req | w_exc_req;

    // A delay-slot victim resumes at its branch.
    assign w_victim_pc = bus.Delayslot_M ? (bus.PC_M - 32'd4) : bus.PC_M;

    assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    // Register state update; a take discards any same-cycle mtc0/eret.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= bus.HWInt;
            if (w_req) begin
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bus.Delayslot_M;
                r_epc       <= w_victim_pc & 32'hFFFF_FFFC;
                r_cause_exc <= w_int_req ? EXC_W'(0) : bus.ExcCode_M;
            end else begin
                if (bus.CP0_WE) begin
                    case (bus.CP0_A)
                        A_SR: begin
                            r_sr_im  <= bus.CP0_WD[15:10];
                            r_sr_exl <= bus.CP0_WD[1];
                            r_sr_ie  <= bus.CP0_WD[0];
                        end
                        A_EPC:   r_epc <= bus.CP0_WD & 32'hFFFF_FFFC;
                        default: ;
                    endcase
                end
                if (bus.ERET_M) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux: pre-write register contents, no bypass.
    always_comb begin
        w_rd = 32'd0;
        case (bus.CP0_A)
            A_SR:    w_rd = w_sr;
            A_CAUSE: w_rd = w_cause;
            A_EPC:   w_rd = r_epc;
            A_PRID:  w_rd = PRID_VAL;
            default: w_rd = 32'd0;
        endcase
    end

    assign bus.CP0_RD  = w_rd;
    assign bus.EPC_Out = r_epc;
    assign bus.Req     = w_req;
    assign bus.NPC_Exc = HANDLER_PC;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: each step drives one cycle of inputs and
// queues the hand-computed Req/CP0_RD/EPC_Out; a monitor checks at negedge.
module tb_cp0_exc_ctrl;
    logic clk;
    logic reset;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        req;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per cycle and compares DUT outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (bus.Req !== e.req) begin
                bad++;
                $display("FAIL %s Req: got %0b want %0b", e.name, bus.Req, e.req);
            end
            total++;
            if (bus.CP0_RD !== e.rd) begin
                bad++;
                $display("FAIL %s CP0_RD: got %h want %h", e.name, bus.CP0_RD, e.rd);
            end
            total++;
            if (bus.EPC_Out !== e.epc) begin
                bad++;
                $display("FAIL %s EPC_Out: got %h want %h", e.name, bus.EPC_Out, e.epc);
            end
            total++;
            if (bus.NPC_Exc !== 32'h0000_4180) begin
                bad++;
                $display("FAIL %s NPC_Exc: got %h want 00004180", e.name, bus.NPC_Exc);
            end
        end
    end

    task automatic step(input string nm, input logic [31:0] pc, input logic [4:0] exc,
                        input logic ds, input logic [5:0] hw, input logic [4:0] a,
                        input logic [31:0] wd, input logic we, input logic er,
                        input logic x_req, input logic [31:0] x_rd, input logic [31:0] x_epc);
        exp_t e;
        @(posedge clk);
        #1;
        bus.PC_M        = pc;
        bus.ExcCode_M   = exc;
        bus.Delayslot_M = ds;
        bus.HWInt       = hw;
        bus.CP0_A       = a;
        bus.CP0_WD      = wd;
        bus.CP0_WE      = we;
        bus.ERET_M      = er;
        e.name = nm;
        e.req  = x_req;
        e.rd   = x_rd;
        e.epc  = x_epc;
        sb.push_back(e);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.PC_M        = 32'h0;
        bus.ExcCode_M   = 5'd0;
        bus.Delayslot_M = 1'b0;
        bus.HWInt       = 6'h3F;
        bus.CP0_A       = 5'd0;
        bus.CP0_WD      = 32'h0;
        bus.CP0_WE      = 1'b0;
        bus.ERET_M      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.HWInt = 6'h0;
        reset     = 1'b0;

        //    name            pc        exc  ds hw     a   wd            we er   req rd            epc
        step("rst_sr",       32'h0,    0, 0, 6'h00, 12, 32'h0,        0, 0,   0, 32'h0,         32'h0);
        step("rst_prid",     32'h0,    0, 0, 6'h00, 15, 32'h0,        0, 0,   0, 32'h1919_0817, 32'h0);
        step("mtc0_sr401",   32'h0,    0, 0, 6'h00, 12, 32'h401,      1, 0,   0, 32'h0,         32'h0);
        step("irq_t0",       32'h3010, 0, 0, 6'h01, 12, 32'h0,        0, 0,   1, 32'h401,       32'h0);
        step("sr_after_irq", 32'h3014, 0, 0, 6'h01, 12, 32'h0,        0, 0,   0, 32'h403,       32'h3010);
        step("cause_irq",    32'h3014, 0, 0, 6'h00, 13, 32'h0,        0, 0,   0, 32'h400,       32'h3010);
        step("mtc0_sr0",     32'h3014, 0, 0, 6'h00, 12, 32'h0,        1, 0,   0, 32'h403,       32'h3010);
        step("exc_ades_bd",  32'h3024, 5, 1, 6'h00, 13, 32'h0,        0, 0,   1, 32'h0,         32'h3010);
        step("cause_ades",   32'h3028, 0, 0, 6'h00, 13, 32'h0,        0, 0,   0, 32'h8000_0014, 32'h3020);
        step("mtc0_sr801",   32'h3028, 0, 0, 6'h00, 12, 32'h801,      1, 0,   0, 32'h2,         32'h3020);
        step("int_over_exc", 32'h3050, 12,0, 6'h02, 12, 32'h0,        0, 0,   1, 32'h801,       32'h3020);
        step("cause_int",    32'h3054, 0, 0, 6'h00, 13, 32'h0,        0, 0,   0, 32'h800,       32'h3050);
        step("exl_block",    32'h3060, 4, 0, 6'h3F, 14, 32'h0,        0, 0,   0, 32'h3050,      32'h3050);
        step("eret",         32'h3064, 0, 0, 6'h3F, 12, 32'h0,        0, 1,   0, 32'h803,       32'h3050);
        step("refire",       32'h3070, 0, 0, 6'h3F, 13, 32'h0,        0, 0,   1, 32'h0000_FC00, 32'h3050);
        step("mtc0_sr0b",    32'h3074, 0, 0, 6'h00, 12, 32'h0,        1, 0,   0, 32'h803,       32'h3070);
        step("exc_vs_mtc0",  32'h3040, 10,0, 6'h00, 14, 32'h3007,     1, 0,   1, 32'h3070,      32'h3070);
        step("epc_kept",     32'h3044, 0, 0, 6'h00, 14, 32'h0,        0, 0,   0, 32'h3040,      32'h3040);
        step("cause_ri",     32'h3044, 0, 0, 6'h00, 13, 32'h0,        0, 0,   0, 32'h28,        32'h3040);
        step("mtc0_cause",   32'h3044, 0, 0, 6'h00, 13, 32'hFFFF_FFFF,1, 0,   0, 32'h28,        32'h3040);
        step("cause_ro",     32'h3044, 0, 0, 6'h00, 13, 32'h0,        0, 0,   0, 32'h28,        32'h3040);
        step("mtc0_prid",    32'h3044, 0, 0, 6'h00, 15, 32'h0,        1, 0,   0, 32'h1919_0817, 32'h3040);
        step("prid_ro",      32'h3044, 0, 0, 6'h00, 15, 32'h0,        0, 0,   0, 32'h1919_0817, 32'h3040);
        step("mtc0_a3",      32'h3044, 0, 0, 6'h00, 3,  32'hFFFF_FFFF,1, 0,   0, 32'h0,         32'h3040);
        step("rd_a3",        32'h3044, 0, 0, 6'h00, 3,  32'h0,        0, 0,   0, 32'h0,         32'h3040);
        step("mtc0_epc",     32'h3044, 0, 0, 6'h00, 14, 32'h3007,     1, 0,   0, 32'h3040,      32'h3040);
        step("eret_new_epc", 32'h3048, 0, 0, 6'h00, 14, 32'h0,        0, 1,   0, 32'h3004,      32'h3004);
        step("sr_post_eret", 32'h3004, 0, 0, 6'h00, 12, 32'h0,        0, 0,   0, 32'h0,         32'h3004);
        step("mtc0_ie_pend", 32'h3008, 0, 0, 6'h01, 12, 32'h401,      1, 0,   0, 32'h0,         32'h3004);
        step("ie_fire",      32'h3100, 0, 0, 6'h01, 12, 32'h0,        0, 0,   1, 32'h401,       32'h3004);
        step("pulse_end",    32'h3104, 0, 0, 6'h01, 14, 32'h0,        0, 0,   0, 32'h3100,      32'h3100);
        step("mtc0_sr_all",  32'h3104, 0, 0, 6'h00, 12, 32'hFFFF_FFFF,1, 0,   0, 32'h403,       32'h3100);
        step("sr_mask",      32'h3104, 0, 0, 6'h00, 12, 32'h0,        0, 0,   0, 32'h0000_FC03, 32'h3100);

        begin : drain
            int waited;
            waited = 0;
            while (sb.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            if (sb.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending want 0", sb.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
